fpmul_param: RTL and testbench

Parametrised IEEE-754-style floating-point multiplier: one control FSM plus datapath in a single block. Exponent and fraction widths are parameters, so one RTL source covers half, single and other formats. The mantissa multiply is iterative shift-add, one bit per cycle. The block adds selectable rounding modes and an inexact flag to the fixed single-precision multiplier, and sits behind the same Start/Done handshake used by the rest of the FP units.

---
 rtl/fpmul_param.sv | 249 ++++++++++++++++++++++++
 tb/tb_fpmul_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_param.sv
// Parametrised floating-point multiplier: control FSM plus datapath with an iterative
// shift-add significand multiply, four rounding modes and a Start/Done handshake.
module fpmul_param #(
  parameter int unsigned EW = 8,
  parameter int unsigned MW = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Start,
  input  logic [EW+MW:0] A,
  input  logic [EW+MW:0] B,
  input  logic [1:0]     RM,
  output logic [EW+MW:0] P,
  output logic           Busy,
  output logic           Done,
  output logic           OF,
  output logic           UF,
  output logic           NV,
  output logic           NX
);
  localparam int unsigned W  = EW + MW + 1;
  localparam int unsigned N  = MW + 1;
  localparam int unsigned XW = EW + 2;
  localparam int unsigned CW = $clog2(N);
  localparam logic signed [XW-1:0] Bias   = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMax   = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] ExpOne = XW'(1);
  localparam logic [W-1:0] QNaN = {1'b0, {EW{1'b1}}, 1'b1, {(MW - 1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StClass, StMul, StNorm, StRound, StPack, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d, res_q, res_d, p_q, p_d;
  logic [1:0]             rm_q, rm_d;
  logic                   sign_q, sign_d, spec_q, spec_d, res_nv_q, res_nv_d;
  logic                   inex_q, inex_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic [N-1:0]           mcand_q, mcand_d;
  logic [2*N-1:0]         prod_q, prod_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MW-1:0]          frac_q, frac_d;
  logic                   of_q, of_d, uf_q, uf_d, nv_q, nv_d, nx_q, nx_d;

  logic                   sa, sb;
  logic [EW-1:0]          ea, eb;
  logic [MW-1:0]          fa, fb;
  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [N:0]             mul_sum;
  logic [MW:0]            frac_sum;
  logic                   grd, stk, lsb, rnd_up, ovf_inf;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  // Multiplier bits consumed from the low end while partial sums enter the high half.
  assign mul_sum = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  assign lsb      = prod_q[MW];
  assign grd      = prod_q[MW-1];
  assign stk      = |prod_q[MW-2:0];
  // Hidden bit is always 1 after NORM, so a fraction carry means the significand hit 2.0.
  assign frac_sum = {1'b0, prod_q[2*MW-1:MW]} + {{MW{1'b0}}, rnd_up};

  always_comb begin
    case (rm_q)
      2'b00:   rnd_up = grd & (stk | lsb);
      2'b01:   rnd_up = 1'b0;
      2'b10:   rnd_up = ~sign_q & (grd | stk);
      default: rnd_up = sign_q & (grd | stk);
    endcase
  end

  always_comb begin
    case (rm_q)
      2'b00:   ovf_inf = 1'b1;
      2'b01:   ovf_inf = 1'b0;
      2'b10:   ovf_inf = ~sign_q;
      default: ovf_inf = sign_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rm_d     = rm_q;
    res_d    = res_q;
    res_nv_d = res_nv_q;
    spec_d   = spec_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    frac_d   = frac_q;
    inex_d   = inex_q;
    p_d      = p_q;
    of_d     = of_q;
    uf_d     = uf_q;
    nv_d     = nv_q;
    nx_d     = nx_q;
    case (state_q)
      StIdle: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          rm_d    = RM;
          of_d    = 1'b0;
          uf_d    = 1'b0;
          nv_d    = 1'b0;
          nx_d    = 1'b0;
          state_d = StClass;
        end
      end
      StClass: begin
        sign_d   = sa ^ sb;
        spec_d   = 1'b1;
        res_nv_d = 1'b0;
        state_d  = StPack;
        if ((a_inf && b_zero) || (a_zero && b_inf)) begin
          res_d    = QNaN;
          res_nv_d = 1'b1;
        end else if (a_nan || b_nan) begin
          res_d = QNaN;
        end else if (a_inf || b_inf) begin
          res_d = {sa ^ sb, {EW{1'b1}}, {MW{1'b0}}};
        end else if (a_zero || b_zero) begin
          res_d = {sa ^ sb, {(W - 1){1'b0}}};
        end else begin
          spec_d  = 1'b0;
          mcand_d = {1'b1, fa};
          prod_d  = {{N{1'b0}}, 1'b1, fb};
          exp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - Bias;
          cnt_d   = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        prod_d = {mul_sum, prod_q[N-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = StNorm;
        end
      end
      StNorm: begin
        // Keep the shifted-out bit alive in the sticky field.
        if (prod_q[2*N-1]) begin
          prod_d = {1'b0, prod_q[2*N-1:2], prod_q[1] | prod_q[0]};
          exp_d  = exp_q + ExpOne;
        end
        state_d = StRound;
      end
      StRound: begin
        inex_d = grd | stk;
        frac_d = frac_sum[MW-1:0];
        if (frac_sum[MW]) begin
          exp_d = exp_q + ExpOne;
        end
        state_d = StPack;
      end
      StPack: begin
        if (spec_q) begin
          p_d  = res_q;
          nv_d = res_nv_q;
        end else if (!exp_q[XW-1] && (exp_q >= EMax)) begin
          p_d  = ovf_inf ? {sign_q, {EW{1'b1}}, {MW{1'b0}}}
                         : {sign_q, {(EW - 1){1'b1}}, 1'b0, {MW{1'b1}}};
          of_d = 1'b1;
          nx_d = 1'b1;
        end else if (exp_q[XW-1] || (exp_q == '0)) begin
          p_d  = {sign_q, {(W - 1){1'b0}}};
          uf_d = 1'b1;
          nx_d = 1'b1;
        end else begin
          p_d  = {sign_q, exp_q[EW-1:0], frac_q};
          nx_d = inex_q;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      rm_q     <= '0;
      res_q    <= '0;
      res_nv_q <= 1'b0;
      spec_q   <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      frac_q   <= '0;
      inex_q   <= 1'b0;
      p_q      <= '0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
      nv_q     <= 1'b0;
      nx_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rm_q     <= rm_d;
      res_q    <= res_d;
      res_nv_q <= res_nv_d;
      spec_q   <= spec_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      frac_q   <= frac_d;
      inex_q   <= inex_d;
      p_q      <= p_d;
      of_q     <= of_d;
      uf_q     <= uf_d;
      nv_q     <= nv_d;
      nx_q     <= nx_d;
    end
  end

  assign P    = p_q;
  assign Busy = (state_q != StIdle);
  assign Done = (state_q == StDone);
  assign OF   = of_q;
  assign UF   = uf_q;
  assign NV   = nv_q;
  assign NX   = nx_q;

endmodule

// File: tb/tb_fpmul_param.sv
// Bench for fpmul_param: single- and half-precision instances checked against an
// exact-arithmetic reference model, plus directed handshake and reset scenarios.
module tb_fpmul_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_start, s_busy, s_done, s_of, s_uf, s_nv, s_nx;
  logic [31:0] s_a, s_b, s_p;
  logic [1:0]  s_rm;
  logic        h_start, h_busy, h_done, h_of, h_uf, h_nv, h_nx;
  logic [15:0] h_a, h_b, h_p;
  logic [1:0]  h_rm;

  fpmul_param u_single (
    .clk(clk), .rst(rst), .Start(s_start), .A(s_a), .B(s_b), .RM(s_rm), .P(s_p),
    .Busy(s_busy), .Done(s_done), .OF(s_of), .UF(s_uf), .NV(s_nv), .NX(s_nx)
  );

  fpmul_param #(.EW(5), .MW(10)) u_half (
    .clk(clk), .rst(rst), .Start(h_start), .A(h_a), .B(h_b), .RM(h_rm), .P(h_p),
    .Busy(h_busy), .Done(h_done), .OF(h_of), .UF(h_uf), .NV(h_nv), .NX(h_nx)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] prev_s, prev_h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_p(input bit half);
    return half ? {16'h0, h_p} : s_p;
  endfunction
  function automatic logic [3:0] cur_fl(input bit half);
    return half ? {h_of, h_uf, h_nv, h_nx} : {s_of, s_uf, s_nv, s_nx};
  endfunction
  function automatic logic cur_busy(input bit half);
    return half ? h_busy : s_busy;
  endfunction
  function automatic logic cur_done(input bit half);
    return half ? h_done : s_done;
  endfunction

  // Exact integer product, rounded by comparing the discarded remainder against half an ulp.
  function automatic void ref_mul(input int ew, input int mw, input logic [31:0] a,
                                  input logic [31:0] b, input logic [1:0] rm,
                                  output logic [31:0] p, output logic [3:0] fl,
                                  output int cyc);
    longint emax, bias, sa, sb, ea, eb, fa, fb, sg, ma, mb, prod, e, sh, q, r, hf, pl;
    longint fmask;
    bit up, a_nan, b_nan, a_inf, b_inf, a_z, b_z;
    emax  = (longint'(1) << ew) - 1;
    bias  = (longint'(1) << (ew - 1)) - 1;
    fmask = (longint'(1) << mw) - 1;
    sa = (longint'(a) >> (ew + mw)) & 1;
    sb = (longint'(b) >> (ew + mw)) & 1;
    ea = (longint'(a) >> mw) & emax;
    eb = (longint'(b) >> mw) & emax;
    fa = longint'(a) & fmask;
    fb = longint'(b) & fmask;
    sg = sa ^ sb;
    a_nan = (ea == emax) && (fa != 0);
    b_nan = (eb == emax) && (fb != 0);
    a_inf = (ea == emax) && (fa == 0);
    b_inf = (eb == emax) && (fb == 0);
    a_z   = (ea == 0);
    b_z   = (eb == 0);
    fl  = 4'b0000;
    cyc = 3;
    if ((a_inf && b_z) || (a_z && b_inf)) begin
      pl = (emax << mw) | (longint'(1) << (mw - 1));
      fl = 4'b0010;
    end else if (a_nan || b_nan) begin
      pl = (emax << mw) | (longint'(1) << (mw - 1));
    end else if (a_inf || b_inf) begin
      pl = (sg << (ew + mw)) | (emax << mw);
    end else if (a_z || b_z) begin
      pl = sg << (ew + mw);
    end else begin
      cyc  = mw + 6;
      ma   = (longint'(1) << mw) | fa;
      mb   = (longint'(1) << mw) | fb;
      prod = ma * mb;
      e    = ea + eb - bias;
      if (prod >= (longint'(1) << (2 * mw + 1))) begin
        sh = mw + 1;
        e++;
      end else begin
        sh = mw;
      end
      q  = prod >> sh;
      r  = prod - (q << sh);
      hf = longint'(1) << (sh - 1);
      case (rm)
        2'b00:   up = (r > hf) || ((r == hf) && ((q & 1) == 1));
        2'b01:   up = 1'b0;
        2'b10:   up = (sg == 0) && (r != 0);
        default: up = (sg == 1) && (r != 0);
      endcase
      if (up) q++;
      if (q == (longint'(2) << mw)) begin
        q = longint'(1) << mw;
        e++;
      end
      if (e >= emax) begin
        fl = 4'b1001;
        if ((rm == 2'b00) || (rm == 2'b10 && sg == 0) || (rm == 2'b11 && sg == 1))
          pl = (sg << (ew + mw)) | (emax << mw);
        else
          pl = (sg << (ew + mw)) | ((emax - 1) << mw) | fmask;
      end else if (e <= 0) begin
        fl = 4'b0101;
        pl = sg << (ew + mw);
      end else begin
        pl = (sg << (ew + mw)) | (e << mw) | (q - (longint'(1) << mw));
        fl = {3'b000, r != 0};
      end
    end
    p = 32'(pl);
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int mw);
    int span, bias, e;
    logic [31:0] v, s, f;
    if ($urandom_range(0, 3) == 0) begin
      v = $urandom;
      return v & ((32'h1 << (ew + mw + 1)) - 1);
    end
    span = 1 << (ew - 2);
    bias = (1 << (ew - 1)) - 1;
    e = bias - span + int'($urandom_range(0, 2 * span));
    s = 32'($urandom_range(0, 1));
    f = $urandom & ((32'h1 << mw) - 1);
    return (s << (ew + mw)) | (32'(e) << mw) | f;
  endfunction

  task automatic drive(input bit half, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] rm);
    if (half) begin
      h_start = st; h_a = a[15:0]; h_b = b[15:0]; h_rm = rm;
    end else begin
      s_start = st; s_a = a; s_b = b; s_rm = rm;
    end
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic do_op(input string tag, input bit half, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] rm, input logic [31:0] ep,
                       input logic [3:0] efl, input int ecyc);
    int cyc;
    drive(half, 1'b1, a, b, rm);
    @(posedge clk); #1;
    drive(half, 1'b0, a, b, rm);
    cyc = 1;
    chk({tag, "/p_held"}, cur_p(half), half ? prev_h : prev_s);
    chk({tag, "/flags_clr"}, {28'h0, cur_fl(half)}, 32'h0);
    while (cur_done(half) !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "/done_cyc"}, 32'(cyc), 32'(ecyc));
    chk({tag, "/p"}, cur_p(half), ep);
    chk({tag, "/flags"}, {28'h0, cur_fl(half)}, {28'h0, efl});
    @(posedge clk); #1;
    chk({tag, "/busy_low"}, {31'h0, cur_busy(half)}, 32'h0);
    chk({tag, "/done_pulse"}, {31'h0, cur_done(half)}, 32'h0);
    chk({tag, "/p_stable"}, cur_p(half), ep);
    if (half) prev_h = ep; else prev_s = ep;
  endtask

  task automatic rand_op_chk(input string tag, input bit half);
    logic [31:0] a, b, ep;
    logic [1:0]  rm;
    logic [3:0]  efl;
    int          ecyc;
    a  = half ? rand_op(5, 10) : rand_op(8, 23);
    b  = half ? rand_op(5, 10) : rand_op(8, 23);
    rm = 2'($urandom_range(0, 3));
    if (half) ref_mul(5, 10, a, b, rm, ep, efl, ecyc);
    else      ref_mul(8, 23, a, b, rm, ep, efl, ecyc);
    do_op(tag, half, a, b, rm, ep, efl, ecyc);
  endtask

  initial begin
    int ndone, dcyc;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 2'b00);
    prev_s = 32'h0;
    prev_h = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p", s_p, 32'h0);
    chk("rst_busy_done_flags", {26'h0, s_busy, s_done, s_of, s_uf, s_nv, s_nx}, 32'h0);
    chk("rst_half", {9'h0, h_p, h_busy, h_done, h_of, h_uf, h_nv, h_nx}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op("mul_3", 1'b0, 32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000, 29);
    do_op("rne", 1'b0, 32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b0001, 29);
    do_op("rtz", 1'b0, 32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 4'b0001, 29);
    do_op("rup", 1'b0, 32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b0001, 29);
    do_op("rdn", 1'b0, 32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800003, 4'b0001, 29);
    do_op("inf_x_0", 1'b0, 32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 4'b0010, 3);
    do_op("ninf", 1'b0, 32'hFF800000, 32'h3F800000, 2'b00, 32'hFF800000, 4'b0000, 3);
    do_op("subn", 1'b0, 32'h00000001, 32'h40000000, 2'b00, 32'h00000000, 4'b0000, 3);
    do_op("qnan", 1'b0, 32'h7FC00000, 32'h12345678, 2'b00, 32'h7FC00000, 4'b0000, 3);
    do_op("ovf_rne", 1'b0, 32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, 4'b1001, 29);
    do_op("ovf_rtz", 1'b0, 32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF, 4'b1001, 29);
    do_op("ovf_rup_neg", 1'b0, 32'hFF000000, 32'h7F000000, 2'b10, 32'hFF7FFFFF, 4'b1001, 29);
    do_op("ovf_rdn_neg", 1'b0, 32'hFF000000, 32'h7F000000, 2'b11, 32'hFF800000, 4'b1001, 29);
    do_op("unf", 1'b0, 32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 4'b0101, 29);
    do_op("h_one", 1'b1, 32'h3C00, 32'h3C00, 2'b00, 32'h3C00, 4'b0000, 16);
    do_op("h_ovf", 1'b1, 32'h7800, 32'h7800, 2'b00, 32'h7C00, 4'b1001, 16);

    for (int i = 0; i < 30; i++) rand_op_chk($sformatf("rnd_s%0d", i), 1'b0);
    for (int i = 0; i < 15; i++) rand_op_chk($sformatf("rnd_h%0d", i), 1'b1);

    // Start pulses inside the MUL phase and in the DONE cycle must be dropped.
    drive(1'b0, 1'b1, 32'h3FC00000, 32'h40000000, 2'b00);
    @(posedge clk); #1;
    s_start = 1'b0;
    ndone = 0;
    dcyc  = 0;
    for (int c = 1; c <= 45; c++) begin
      if (s_done) begin
        ndone++;
        dcyc = c;
      end
      s_start = (c == 5 || c == 29);
      @(posedge clk); #1;
    end
    s_start = 1'b0;
    chk("hs_done_count", 32'(ndone), 32'd1);
    chk("hs_done_cyc", 32'(dcyc), 32'd29);
    chk("hs_p", s_p, 32'h40400000);
    chk("hs_busy_low", {31'h0, s_busy}, 32'h0);
    prev_s = 32'h40400000;

    drive(1'b0, 1'b1, 32'h3FC00000, 32'h40000000, 2'b00);
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, s_busy}, 32'h0);
    chk("midrst_p", s_p, 32'h0);
    chk("midrst_done_flags", {27'h0, s_done, s_of, s_uf, s_nv, s_nx}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    prev_s = 32'h0;
    prev_h = 32'h0;
    do_op("after_rst", 1'b0, 32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000, 29);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
